fifo_param: RTL
===============

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (>=1) SHALL be supported.
REQ-002 Parameter DEPTH, default 8, number of storage locations, power of two >=2, SHALL be supported.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, almost_full threshold in words, range 1..DEPTH, SHALL be supported.
REQ-004 Parameter AE_LEVEL, default 1, almost_empty threshold in words, range 0..DEPTH-1, SHALL be supported.
REQ-005 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode, SHALL be supported.
REQ-006 Port ck  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 Port rst  input  1  reset; synchronous and active-high.
REQ-008 Port wr  input  1  write request.
REQ-009 Port datain  input  DATA_W  write data.
REQ-010 Port rd  input  1  read request (FWFT=1: pop of head word).
REQ-011 Port dataout  output  DATA_W  read data.
REQ-012 Port full / empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-013 Port almost_full / almost_empty  output  1 each  count >= AF_LEVEL / count <= AE_LEVEL.
REQ-014 Port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 Port overflow / underflow  output  1 each  sticky error flags.
REQ-016 Port clr_err  input  1  clears sticky error flags.

Function
REQ-017 A write SHALL be accepted when wr=1 and (full=0, or full=1 with a read accepted in the same cycle); accepted data stored at write pointer, pointer +1 modulo DEPTH.
REQ-018 A read SHALL be accepted when rd=1 and empty=0; read pointer +1 modulo DEPTH; rd while empty SHALL be ignored (no pointer/count change), including when wr=1 that cycle (no bypass).
REQ-019 count SHALL +1 on write-only accept, -1 on read-only accept, hold on both or neither; never exceed DEPTH nor go below 0.
REQ-020 full, empty, almost_full, almost_empty SHALL be decoded from registered count and valid the cycle after the causing edge.
REQ-021 FWFT=0: dataout SHALL load the word at read pointer on the edge of an accepted read (1-cycle latency) and hold otherwise.
REQ-022 FWFT=1: dataout SHALL combinationally show the word at read pointer; valid whenever empty=0; a word written into an empty FIFO SHALL appear the cycle after its write edge.
REQ-023 Simultaneous accepted read and write when full SHALL return the oldest word and store the new one; full stays 1.
REQ-024 overflow SHALL set on wr=1 with write rejected; underflow SHALL set on rd=1 with empty=1; both hold until clr_err or rst.
REQ-025 clr_err=1 SHALL clear both error flags on the next edge; if a new error occurs in the same cycle, set SHALL win.
REQ-026 Pointers SHALL wrap seamlessly; data order SHALL be preserved across any number of wraps.

Reset
REQ-027 rst=1 at an edge SHALL take priority over wr, rd, clr_err in that cycle.
REQ-028 After reset: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, dataout 0, all storage locations 0.
REQ-029 Reset mid-operation SHALL discard all stored words; first read after refill SHALL return the first post-reset write.

Verification (DATA_W=8, DEPTH=8, defaults unless stated)
REQ-030 Fill: write 0x81,0x82,0x01,0x83,0x84,0x02,0x03,0x02 -> count 8, full 1, almost_full 1 from 7th word; 9th write 0x87 rejected, overflow 1, contents unchanged.
REQ-031 Drain: 8 reads after REQ-030 -> dataout 0x81..0x02 in write order, 1 cycle after each rd; empty 1 after last; extra rd -> underflow 1, dataout holds 0x02.
REQ-032 Full + simultaneous rd/wr of 0x8E for 4 cycles -> count stays 8, outputs oldest 4 words, 0x8E written 4 times, no overflow.
REQ-033 Wrap: 20 cycles of interleaved single write/read of 0x00..0x13 -> outputs 0x00..0x13 in order, count never >1.
REQ-034 FWFT=1: write 0x55 into empty -> dataout 0x55 next cycle with rd=0; rd -> empty 1 next cycle.
REQ-035 Reset with count 5, overflow 1 and wr=rd=1 -> all REQ-028 values next cycle; clr_err with concurrent error -> flag stays 1.

Source files
------------

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - single-clock parameterised FIFO with registered or first-word-fall-through reads
module fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = 0
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [DATA_W-1:0]        datain,
    input  logic                     rd,
    output logic [DATA_W-1:0]        dataout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              rd_acc, wr_acc;

    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A full FIFO still takes a write when a read frees the head slot in the same cycle.
    assign rd_acc = rd && !empty;
    assign wr_acc = wr && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
        if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
        else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (wr && !wr_acc) ovf_d = 1'b1;
        if (rd && empty)   unf_d = 1'b1;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            if (wr_acc) mem_q[wr_ptr_q] <= datain;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dataout = mem_q[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge ck) begin
                if (rst)         dout_q <= '0;
                else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
            end
            assign dataout = dout_q;
        end
    endgenerate
endmodule
